prog_tick_counter: RTL and testbench

- Parametrised successor to the board-level divided-clock down counter.
- Every register runs on `clk`. A programmable prescaler produces a single-cycle clock-enable (`tick`); no derived clock is generated.
- A WIDTH-bit counter steps on each tick. It supports up/down direction, synchronous load, and wrap, saturate and one-shot modes, with terminal-count and done flags.
- Intended to drive display/LED demo logic and timers in the CPU project.

---
 rtl/prog_tick_counter.sv | 92 +++++++++
 tb/tb_prog_tick_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/prog_tick_counter.sv
// Programmable-prescaler tick counter: a single-cycle clock-enable steps a WIDTH-bit
// up/down counter with wrap, saturate and one-shot terminal behaviour.
module prog_tick_counter #(
  parameter int                 WIDTH       = 4,
  parameter int                 DIV_WIDTH   = 24,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_limit,
  input  logic                 dir,
  input  logic [1:0]           mode,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_value,
  output logic [WIDTH-1:0]     count,
  output logic                 tick,
  output logic                 tc,
  output logic                 done
);

  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;

  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic                 tick_q, tick_d;
  logic                 tc_q, tc_d;
  logic                 done_q, done_d;

  logic                 fire;
  logic [WIDTH-1:0]     term_value;
  logic                 at_term;

  // >= rather than == so a lowered limit takes effect at once instead of wrapping.
  assign fire       = en && (presc_q >= div_limit);
  assign term_value = dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  assign at_term    = (count_q == term_value);

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    done_d  = done_q;

    if (load) begin
      count_d = load_value;
      presc_d = '0;
      done_d  = 1'b0;
    end else if (fire) begin
      presc_d = '0;
      tick_d  = 1'b1;
      if (!done_q) begin
        if (!at_term) begin
          count_d = dir ? count_q + 1'b1 : count_q - 1'b1;
        end else begin
          tc_d = 1'b1;
          case (mode)
            MODE_SAT: count_d = count_q;
            MODE_ONE: done_d  = 1'b1;
            default:  count_d = dir ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
          endcase
        end
      end
    end else if (en) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      count_q <= RESET_VALUE;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_prog_tick_counter.sv
// Directed bench for prog_tick_counter: prescaler timing, wrap/saturate/one-shot,
// enable freeze, limit changes and load/reset priority.
module tb_prog_tick_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [23:0] div_limit;
  logic        dir;
  logic [1:0]  mode;
  logic        load;
  logic [3:0]  load_value;
  logic [3:0]  count;
  logic        tick;
  logic        tc;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  prog_tick_counter #(.WIDTH(4), .DIV_WIDTH(24), .RESET_VALUE(4'hF)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .div_limit  (div_limit),
    .dir        (dir),
    .mode       (mode),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .tick       (tick),
    .tc         (tc),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Steps until tick is seen, bounded to 64 cycles; returns cycles taken.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 64);
  endtask

  int n;

  initial begin
    reset = 1'b0; en = 1'b1; div_limit = 24'd3; dir = 1'b0; mode = 2'b00;
    load = 1'b0; load_value = 4'd0;

    // Reset state
    step(); step();
    check("rst_count", 32'(count), 32'd15);
    check("rst_tick",  32'(tick),  32'd0);
    check("rst_tc",    32'(tc),    32'd0);
    check("rst_done",  32'(done),  32'd0);
    reset = 1'b1;

    // Down-count wrap, tick every 4 cycles
    for (int i = 14; i >= 0; i--) begin
      wait_tick(n);
      check("down_period", 32'(n), 32'd4);
      check("down_count",  32'(count), 32'(i));
      check("down_tc",     32'(tc), 32'd0);
    end
    wait_tick(n);
    check("wrap_period", 32'(n), 32'd4);
    check("wrap_count",  32'(count), 32'd15);
    check("wrap_tc",     32'(tc), 32'd1);
    step();
    check("wrap_tick_low", 32'(tick), 32'd0);
    check("wrap_tc_low",   32'(tc),   32'd0);

    // Up saturate
    dir = 1'b1; mode = 2'b01; load = 1'b1; load_value = 4'd13;
    step();
    load = 1'b0;
    check("sat_load_count", 32'(count), 32'd13);
    check("sat_load_tick",  32'(tick),  32'd0);
    wait_tick(n);
    check("sat_period", 32'(n), 32'd4);
    check("sat_14", 32'(count), 32'd14);
    wait_tick(n);
    check("sat_15", 32'(count), 32'd15);
    check("sat_15_tc", 32'(tc), 32'd0);
    for (int i = 0; i < 2; i++) begin
      wait_tick(n);
      check("sat_hold_period", 32'(n), 32'd4);
      check("sat_hold_count", 32'(count), 32'd15);
      check("sat_hold_tc",    32'(tc),    32'd1);
    end

    // Down one-shot
    dir = 1'b0; mode = 2'b10; load = 1'b1; load_value = 4'd2;
    step();
    load = 1'b0;
    check("os_load_count", 32'(count), 32'd2);
    wait_tick(n);
    check("os_1", 32'(count), 32'd1);
    wait_tick(n);
    check("os_0", 32'(count), 32'd0);
    check("os_0_done", 32'(done), 32'd0);
    wait_tick(n);
    check("os_term_count", 32'(count), 32'd0);
    check("os_term_tc",    32'(tc),    32'd1);
    check("os_term_done",  32'(done),  32'd1);
    wait_tick(n);
    check("os_after_count", 32'(count), 32'd0);
    check("os_after_tc",    32'(tc),    32'd0);
    check("os_after_done",  32'(done),  32'd1);
    check("os_after_tick",  32'(tick),  32'd1);
    load = 1'b1; load_value = 4'd5;
    step();
    load = 1'b0;
    check("os_reload_count", 32'(count), 32'd5);
    check("os_reload_done",  32'(done),  32'd0);

    // div_limit=0: tick every cycle; enable freeze
    mode = 2'b00; div_limit = 24'd0;
    step();
    check("fast_4", 32'(count), 32'd4);
    check("fast_4_tick", 32'(tick), 32'd1);
    step();
    check("fast_3", 32'(count), 32'd3);
    check("fast_3_tick", 32'(tick), 32'd1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("freeze_count", 32'(count), 32'd3);
      check("freeze_tick",  32'(tick),  32'd0);
      check("freeze_presc", 32'(dut.presc_q), 32'd0);
    end
    en = 1'b1;
    step();
    check("unfreeze_count", 32'(count), 32'd2);
    check("unfreeze_tick",  32'(tick),  32'd1);

    // Raise limit 0 -> 7 at presc=0
    div_limit = 24'd7;
    wait_tick(n);
    check("raise_period", 32'(n), 32'd8);
    check("raise_count",  32'(count), 32'd1);

    // Lower limit 7 -> 2 at presc=5
    for (int i = 0; i < 5; i++) begin
      step();
      check("lower_wait_tick", 32'(tick), 32'd0);
    end
    check("lower_presc", 32'(dut.presc_q), 32'd5);
    div_limit = 24'd2;
    step();
    check("lower_tick",  32'(tick),  32'd1);
    check("lower_count", 32'(count), 32'd0);

    // Load collides with fire
    div_limit = 24'd0; load = 1'b1; load_value = 4'd9;
    step();
    load = 1'b0;
    check("loadfire_count", 32'(count), 32'd9);
    check("loadfire_tick",  32'(tick),  32'd0);
    check("loadfire_tc",    32'(tc),    32'd0);
    check("loadfire_presc", 32'(dut.presc_q), 32'd0);

    // Reset collides with load
    reset = 1'b0; load = 1'b1; load_value = 4'd6;
    step();
    reset = 1'b1; load = 1'b0;
    check("rstload_count", 32'(count), 32'd15);
    check("rstload_tick",  32'(tick),  32'd0);
    check("rstload_done",  32'(done),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
